ysyx_22041752_commit_ctrl: RTL
==============================

// Module: ysyx_22041752_commit_ctrl
// PURPOSE
//  Sequences retired-instruction trace from the WB stage to the DPI-C difftest
//  consumer. Buffers WB commits in a small FIFO, presents them one per handshake,
//  back-pressures WB when full, and runs the halt sequence: drain, then freeze.
//  Sits between the WB stage and the DPI trace/record module, replacing ad-hoc
//  delay-register alignment with explicit valid/ready sequencing.
// PARAMETERS
//  DEPTH    4   FIFO entries; power of 2, >=2
//  PC_WD    64  PC width
//  INST_WD  32  instruction width
//  RA_WD    5   register-file address width
//  RD_WD    64  register-file data width
// PORTS
//  clk          in   1        clock
//  rst_n        in   1        async active-low reset
//  ws_valid     in   1        WB stage retires an instruction this cycle
//  ws_pc        in   PC_WD    retired PC
//  ws_inst      in   INST_WD  retired instruction
//  ws_rf_wen    in   1        GPR write enable
//  ws_rf_wnum   in   RA_WD    GPR write index
//  ws_rf_wdata  in   RD_WD    GPR write data
//  ws_stop      in   1        retired instruction is the halt (ebreak) instruction
//  commit_stall out  1        WB must hold its instruction; = full | state!=RUN
//  tr_valid     out  1        trace entry available (FIFO not empty)
//  tr_ready     in   1        consumer takes entry this cycle
//  tr_pc        out  PC_WD    head entry PC
//  tr_inst      out  INST_WD  head entry instruction
//  tr_wen       out  1        head entry GPR write enable (0 if wnum==0)
//  tr_wnum      out  RA_WD    head entry GPR index
//  tr_wdata     out  RD_WD    head entry GPR data
//  tr_halt      out  1        head entry is the halt instruction
//  halted       out  1        halt sequence complete; sticky
//  commit_cnt   out  64       count of entries popped
// BEHAVIOUR
//  Reset (async, rst_n=0): FIFO empty, rd/wr ptrs 0, state RUN, halted=0,
//   commit_cnt=0, tr_valid=0, commit_stall=0; tr_* data undefined but stable.
//  Push: ws_valid & !commit_stall. Entry stores pc, inst, wen&(wnum!=0), wnum,
//   wdata, ws_stop. Pushed at edge N -> tr_valid=1 from cycle N+1 (1-cycle latency).
//  Pop: tr_valid & tr_ready. tr_* driven combinationally from head entry.
//   commit_cnt += 1 per pop; wraps 2^64-1 -> 0.
//  Full: commit_stall=1 even if a pop happens same cycle (no push-on-full bypass).
//  Empty: push+pop same cycle impossible for the new entry (no fall-through).
//  Non-empty, non-full push+pop same cycle: count unchanged, both ptrs advance.
//  Pointers log2(DEPTH) bits + 1 wrap bit; full = same index, differing wrap bit.
//  FSM:
//   RUN   : accept pushes. Push with ws_stop=1 -> DRAIN.
//   DRAIN : commit_stall=1, ws_valid ignored. Pop of entry with halt flag -> HALT.
//   HALT  : halted=1, commit_stall=1, no pushes; remaining entries still
//           poppable (none expected). Exit only by reset.
//  ws_valid=0 with ws_stop=1: ignored. ws_stop with full FIFO: not accepted,
//   WB holds; transition occurs on the cycle the push is accepted.
//  tr_ready while tr_valid=0: no effect, no count.
//  Reset mid-operation: all entries discarded, FSM to RUN, halted cleared.
// TESTING
//  1 Reset: rst_n=0 mid-cycle -> tr_valid=0, halted=0, commit_cnt=0 immediately.
//  2 Single commit pc=0x80000000 inst=0x00000013 wen=1 wnum=0, tr_ready=1 ->
//    tr_valid next cycle, tr_wen=0, commit_cnt=1 after pop.
//  3 Fill: 4 commits, tr_ready=0 -> commit_stall=1 after 4th; 5th ws_valid held;
//    one pop -> stall drops next cycle, 5th pushed, pops return order pc+0,4,..,16.
//  4 Full + simultaneous pop and ws_valid -> pop only; push next cycle.
//  5 Halt: commits A,B, then ebreak with ws_stop=1, tr_ready=0 -> state DRAIN,
//    further ws_valid ignored; release ready -> A,B,ebreak popped, tr_halt=1 on
//    ebreak, halted=1 cycle after its pop, commit_cnt=3.
//  6 Reset in DRAIN with 2 entries -> FIFO empty, RUN, halted=0, new commit accepted.

Source files
------------

// File: rtl/ysyx_22041752_commit_ctrl.sv
// Commit sequencer between the WB stage and the difftest trace consumer.
// WB commits are buffered in a small FIFO and handed out one per valid/ready
// handshake. A retired halt instruction starts a drain: WB is frozen, the
// remaining entries are emptied, and popping the halt entry freezes the block
// until reset.
module ysyx_22041752_commit_ctrl #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PC_WD   = 64,
  parameter int unsigned INST_WD = 32,
  parameter int unsigned RA_WD   = 5,
  parameter int unsigned RD_WD   = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_ws_valid,
  input  logic [PC_WD-1:0]   i_ws_pc,
  input  logic [INST_WD-1:0] i_ws_inst,
  input  logic               i_ws_rf_wen,
  input  logic [RA_WD-1:0]   i_ws_rf_wnum,
  input  logic [RD_WD-1:0]   i_ws_rf_wdata,
  input  logic               i_ws_stop,
  output logic               o_commit_stall,
  output logic               o_tr_valid,
  input  logic               i_tr_ready,
  output logic [PC_WD-1:0]   o_tr_pc,
  output logic [INST_WD-1:0] o_tr_inst,
  output logic               o_tr_wen,
  output logic [RA_WD-1:0]   o_tr_wnum,
  output logic [RD_WD-1:0]   o_tr_wdata,
  output logic               o_tr_halt,
  output logic               o_halted,
  output logic [63:0]        o_commit_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StRun, StDrain, StHalt} state_e;

  state_e r_state;
  state_e w_state_nxt;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;

  logic [PC_WD-1:0]   r_pc    [DEPTH];
  logic [INST_WD-1:0] r_inst  [DEPTH];
  logic               r_wen   [DEPTH];
  logic [RA_WD-1:0]   r_wnum  [DEPTH];
  logic [RD_WD-1:0]   r_wdata [DEPTH];
  logic               r_halt  [DEPTH];

  logic [63:0] r_commit_cnt;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_stall;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  // Stall depends only on registered state, so a pop never frees a slot for
  // a push in the same cycle.
  assign w_stall = w_full || (r_state != StRun);
  assign w_push  = i_ws_valid && !w_stall;
  assign w_pop   = !w_empty && i_tr_ready;

  // Pointer and commit counter update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_commit_cnt <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      if (w_pop) begin
        r_rptr       <= r_rptr + {{AW{1'b0}}, 1'b1};
        r_commit_cnt <= r_commit_cnt + 64'd1;
      end
    end
  end

  // Entry storage; contents are meaningless while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[r_wptr[AW-1:0]]    <= i_ws_pc;
      r_inst[r_wptr[AW-1:0]]  <= i_ws_inst;
      r_wen[r_wptr[AW-1:0]]   <= i_ws_rf_wen && (i_ws_rf_wnum != '0);
      r_wnum[r_wptr[AW-1:0]]  <= i_ws_rf_wnum;
      r_wdata[r_wptr[AW-1:0]] <= i_ws_rf_wdata;
      r_halt[r_wptr[AW-1:0]]  <= i_ws_stop;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StRun;
    else        r_state <= w_state_nxt;
  end

  // FSM next state: enter drain on an accepted halt, halt once it is popped.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StRun:   if (w_push && i_ws_stop) w_state_nxt = StDrain;
      StDrain: if (w_pop && r_halt[r_rptr[AW-1:0]]) w_state_nxt = StHalt;
      StHalt:  w_state_nxt = StHalt;
      default: w_state_nxt = StRun;
    endcase
  end

  // Outputs: status flags and the head entry presented combinationally.
  always_comb begin
    o_commit_stall = w_stall;
    o_halted       = (r_state == StHalt);
    o_tr_valid     = !w_empty;
    o_tr_pc        = r_pc[r_rptr[AW-1:0]];
    o_tr_inst      = r_inst[r_rptr[AW-1:0]];
    o_tr_wen       = r_wen[r_rptr[AW-1:0]];
    o_tr_wnum      = r_wnum[r_rptr[AW-1:0]];
    o_tr_wdata     = r_wdata[r_rptr[AW-1:0]];
    o_tr_halt      = r_halt[r_rptr[AW-1:0]];
    o_commit_cnt   = r_commit_cnt;
  end

endmodule
